vga_timing_gen: RTL and testbench

Parametrised successor to the fixed 640x480 VGA timer. Generates the pixel-enable prescale, x/y raster counters, sync pulses, active-video and blanking flags, and line/frame strobes for any mode set by parameters. Sits between the board clock and the frame-buffer/sprite pixel pipeline, feeding the VGA output pins.

---
 rtl/vga_timing_pkg.sv | 49 ++++
 rtl/vga_timing_if.sv | 24 ++
 rtl/vga_timing_raster_counter.sv | 37 +++
 rtl/vga_timing_gen.sv | 177 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Holds ready-made mode parameter sets and the arithmetic used to derive
// line/frame totals and counter widths from them.
package vga_timing_pkg;

  // Complete description of one video mode.
  typedef struct packed {
    int clk_div;
    int h_visible;
    int h_front;
    int h_sync;
    int h_back;
    int v_visible;
    int v_front;
    int v_sync;
    int v_back;
    int h_pol;
    int v_pol;
  } vga_mode_t;

  // 640x480@60: 25 MHz pixel clock from a 100 MHz board clock, negative syncs.
  localparam vga_mode_t MODE_640X480_60 = '{
    clk_div: 4, h_visible: 640, h_front: 16, h_sync: 96, h_back: 48,
    v_visible: 480, v_front: 10, v_sync: 2, v_back: 33, h_pol: 0, v_pol: 0
  };

  // 800x600@60: 40 MHz pixel clock taken directly as the system clock, positive syncs.
  localparam vga_mode_t MODE_800X600_60 = '{
    clk_div: 1, h_visible: 800, h_front: 40, h_sync: 128, h_back: 88,
    v_visible: 600, v_front: 1, v_sync: 4, v_back: 23, h_pol: 1, v_pol: 1
  };

  // Total pixels per line or lines per frame.
  function automatic int span_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  // Counter width able to hold 0..total-1 (never narrower than one bit).
  function automatic int count_bits(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

  // Inclusive window test used by the sync decoders.
  function automatic logic in_range(input int value, input int lo, input int hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator (master) and the pixel
// pipeline / output stage (slave).
interface vga_timing_if #(
  parameter int XBITS = 10,
  parameter int YBITS = 10
);
  logic             pixel_tick;
  logic [XBITS-1:0] x;
  logic [YBITS-1:0] y;
  logic             hsync;
  logic             vsync;
  logic             activevideo;
  logic             vblank;
  logic             line_start;
  logic             frame_start;

  modport master (
    output pixel_tick, x, y, hsync, vsync, activevideo, vblank, line_start, frame_start
  );

  modport slave (
    input pixel_tick, x, y, hsync, vsync, activevideo, vblank, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_raster_counter.sv
// Wrapping counter 0..MAX with enable. count_next exposes the value the
// counter takes at the next edge so the parent can register decodes that
// line up with count; carry flags the enabled step that wraps to zero.
module raster_counter #(
  parameter int MAX   = 799,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             carry
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX);

  // Next-count and wrap-carry computation.
  always_comb begin
    carry = en && (count == LAST);
    if (!en) begin
      count_next = count;
    end else if (count == LAST) begin
      count_next = '0;
    end else begin
      count_next = count + WIDTH'(1'b1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-enable prescaler, x/y
// counters, sync pulses, active/blanking flags and line/frame strobes.
// Optional build macro VGA_TIMING_PIPE_EN delays hsync/vsync/activevideo by
// PIPE_DELAY pixel ticks to match a pipelined pixel path.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int H_POL     = 0,
  parameter int V_POL     = 0,
`ifdef VGA_TIMING_PIPE_EN
  parameter int PIPE_DELAY = 2,
`endif
  parameter int XBITS = count_bits(span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK)),
  parameter int YBITS = count_bits(span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK))
) (
  input  logic clk,
  input  logic reset,
  vga_timing_if.master vga
);
  localparam int H_TOTAL  = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL  = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int HS_FIRST = H_VISIBLE + H_FRONT;
  localparam int HS_LAST  = H_VISIBLE + H_FRONT + H_SYNC - 1;
  localparam int VS_FIRST = V_VISIBLE + V_FRONT;
  localparam int VS_LAST  = V_VISIBLE + V_FRONT + V_SYNC - 1;
  localparam int DIV_BITS = count_bits(CLK_DIV);
  localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(CLK_DIV - 1);
  localparam logic HS_ON  = (H_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_ON  = (V_POL != 0) ? 1'b1 : 1'b0;

  if (CLK_DIV < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_params
    $fatal(1, "vga_timing_gen: CLK_DIV must be >= 1 and porch/sync widths nonzero");
  end

  logic [DIV_BITS-1:0] div_cnt;
  logic [DIV_BITS-1:0] div_next;
  logic                tick;
  logic [XBITS-1:0]    x;
  logic [XBITS-1:0]    x_next;
  logic                x_wrap;
  logic [YBITS-1:0]    y;
  logic [YBITS-1:0]    y_next;
  logic                y_wrap;
  logic                vblank_r;
  logic                line_start_r;
  logic                frame_start_r;

  // Prescaler next value: wraps after CLK_DIV system clocks.
  always_comb begin
    if (div_cnt == DIV_LAST) begin
      div_next = '0;
    end else begin
      div_next = div_cnt + DIV_BITS'(1'b1);
    end
  end

  // Prescaler and pixel_tick register; tick is high while div_cnt sits at its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= div_next;
      tick    <= (div_next == DIV_LAST);
    end
  end

  raster_counter #(.MAX(H_TOTAL - 1), .WIDTH(XBITS)) u_x_counter (
    .clk       (clk),
    .reset     (reset),
    .en        (tick),
    .count     (x),
    .count_next(x_next),
    .carry     (x_wrap)
  );

  raster_counter #(.MAX(V_TOTAL - 1), .WIDTH(YBITS)) u_y_counter (
    .clk       (clk),
    .reset     (reset),
    .en        (x_wrap),
    .count     (y),
    .count_next(y_next),
    .carry     (y_wrap)
  );

  // Blanking flag and strobes, registered from the next raster position so they align with x/y.
  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_r      <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      vblank_r      <= (int'(y_next) >= V_VISIBLE);
      line_start_r  <= x_wrap;
      frame_start_r <= x_wrap && y_wrap;
    end
  end

`ifdef VGA_TIMING_PIPE_EN
  if (PIPE_DELAY < 1) begin : g_bad_pipe
    $fatal(1, "vga_timing_gen: PIPE_DELAY must be >= 1");
  end

  logic [PIPE_DELAY-1:0] hs_pipe;
  logic [PIPE_DELAY-1:0] vs_pipe;
  logic [PIPE_DELAY-1:0] av_pipe;
  logic                  hs_cur;
  logic                  vs_cur;
  logic                  av_cur;

  // Sync/active levels of the current raster position, fed into the delay line.
  always_comb begin
    hs_cur = in_range(int'(x), HS_FIRST, HS_LAST) ? HS_ON : ~HS_ON;
    vs_cur = in_range(int'(y), VS_FIRST, VS_LAST) ? VS_ON : ~VS_ON;
    av_cur = (int'(x) < H_VISIBLE) && (int'(y) < V_VISIBLE);
  end

  // Delay line advanced once per pixel; resets to inactive levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_pipe <= {PIPE_DELAY{~HS_ON}};
      vs_pipe <= {PIPE_DELAY{~VS_ON}};
      av_pipe <= '0;
    end else if (tick) begin
      hs_pipe <= PIPE_DELAY'({hs_pipe, hs_cur});
      vs_pipe <= PIPE_DELAY'({vs_pipe, vs_cur});
      av_pipe <= PIPE_DELAY'({av_pipe, av_cur});
    end else begin
      hs_pipe <= hs_pipe;
      vs_pipe <= vs_pipe;
      av_pipe <= av_pipe;
    end
  end

  assign vga.hsync       = hs_pipe[PIPE_DELAY-1];
  assign vga.vsync       = vs_pipe[PIPE_DELAY-1];
  assign vga.activevideo = av_pipe[PIPE_DELAY-1];
`else
  logic hsync_r;
  logic vsync_r;
  logic active_r;

  // Sync and active flags registered from the next position: zero latency against x/y.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_r  <= ~HS_ON;
      vsync_r  <= ~VS_ON;
      active_r <= 1'b1;
    end else begin
      hsync_r  <= in_range(int'(x_next), HS_FIRST, HS_LAST) ? HS_ON : ~HS_ON;
      vsync_r  <= in_range(int'(y_next), VS_FIRST, VS_LAST) ? VS_ON : ~VS_ON;
      active_r <= (int'(x_next) < H_VISIBLE) && (int'(y_next) < V_VISIBLE);
    end
  end

  assign vga.hsync       = hsync_r;
  assign vga.vsync       = vsync_r;
  assign vga.activevideo = active_r;
`endif

  assign vga.pixel_tick  = tick;
  assign vga.x           = x;
  assign vga.y           = y;
  assign vga.vblank      = vblank_r;
  assign vga.line_start  = line_start_r;
  assign vga.frame_start = frame_start_r;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 mode, the 800x600
// CLK_DIV=1 positive-sync mode, and a tiny mode small enough to scan whole
// frames. Also builds with VGA_TIMING_PIPE_EN (sync/active delayed 2 ticks).
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

`ifdef VGA_TIMING_PIPE_EN
  localparam int   PD     = 2;
  localparam logic AV_RST = 1'b0;
`else
  localparam int   PD     = 0;
  localparam logic AV_RST = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset_def;
  logic reset_hd;
  logic reset_sm;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_timing_if #(.XBITS(10), .YBITS(10)) d_if ();
  vga_timing_if #(.XBITS(11), .YBITS(10)) h_if ();
  vga_timing_if #(.XBITS(4),  .YBITS(3))  s_if ();

  vga_timing_gen u_def (.clk(clk), .reset(reset_def), .vga(d_if));

  vga_timing_gen #(
    .CLK_DIV  (MODE_800X600_60.clk_div),
    .H_VISIBLE(MODE_800X600_60.h_visible), .H_FRONT(MODE_800X600_60.h_front),
    .H_SYNC   (MODE_800X600_60.h_sync),    .H_BACK (MODE_800X600_60.h_back),
    .V_VISIBLE(MODE_800X600_60.v_visible), .V_FRONT(MODE_800X600_60.v_front),
    .V_SYNC   (MODE_800X600_60.v_sync),    .V_BACK (MODE_800X600_60.v_back),
    .H_POL    (MODE_800X600_60.h_pol),     .V_POL  (MODE_800X600_60.v_pol)
  ) u_hd (.clk(clk), .reset(reset_hd), .vga(h_if));

  // Tiny mode: 15 pixels x 8 lines, two clocks per pixel -> 240 clocks per frame.
  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .H_POL(0), .V_POL(0)
  ) u_sm (.clk(clk), .reset(reset_sm), .vga(s_if));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int   d_hs_fall = -1, d_hs_rise = -1, d_av_fall = -1, d_hs_low = 0;
  int   h_hs_rise = -1, h_hs_fall = -1, h_hs_high = 0;
  int   p, ym;
  logic d_hs_prev, d_av_prev, h_hs_prev;
  bit   found;

  initial begin
    reset_def = 1'b1;
    reset_hd  = 1'b1;
    reset_sm  = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_tick",   32'(d_if.pixel_tick),  32'(1'b0));
    check("rst_x",      32'(d_if.x),           32'd0);
    check("rst_y",      32'(d_if.y),           32'd0);
    check("rst_hsync",  32'(d_if.hsync),       32'(1'b1));
    check("rst_vsync",  32'(d_if.vsync),       32'(1'b1));
    check("rst_active", 32'(d_if.activevideo), 32'(AV_RST));
    check("rst_vblank", 32'(d_if.vblank),      32'(1'b0));
    check("rst_ls",     32'(d_if.line_start),  32'(1'b0));
    check("rst_fs",     32'(d_if.frame_start), 32'(1'b0));
    check("hd_rst_tick",  32'(h_if.pixel_tick), 32'(1'b0));
    check("hd_rst_hsync", 32'(h_if.hsync),      32'(1'b0));
    check("sm_rst_x",     32'(s_if.x),          32'd0);

    d_hs_prev = d_if.hsync;
    d_av_prev = d_if.activevideo;
    h_hs_prev = h_if.hsync;
    reset_def = 1'b0;
    reset_hd  = 1'b0;
    reset_sm  = 1'b0;

    // k counts clock edges since reset release; sampled on the falling edge.
    for (int k = 1; k <= 3300; k++) begin
      @(negedge clk);
      // Default mode: one tick every 4 clocks, x steps on the edge after a tick.
      check("def_tick",  32'(d_if.pixel_tick),  32'(k % 4 == 3));
      check("def_x",     32'(d_if.x),           32'((k / 4) % 800));
      check("def_y",     32'(d_if.y),           32'((k / 4) / 800));
      check("def_ls",    32'(d_if.line_start),  32'(k == 3200));
      check("def_fs",    32'(d_if.frame_start), 32'(1'b0));
      check("def_vsync", 32'(d_if.vsync),       32'(1'b1));
      if (d_hs_prev && !d_if.hsync && d_hs_fall < 0) d_hs_fall = int'(d_if.x);
      if (!d_hs_prev && d_if.hsync && d_hs_rise < 0) d_hs_rise = int'(d_if.x);
      if (d_av_prev && !d_if.activevideo && d_av_fall < 0) d_av_fall = int'(d_if.x);
      if (!d_if.hsync && k < 3200) d_hs_low++;
      d_hs_prev = d_if.hsync;
      d_av_prev = d_if.activevideo;

      // 800x600, CLK_DIV=1: tick every clock once out of reset.
      check("hd_tick", 32'(h_if.pixel_tick), 32'(1'b1));
      check("hd_x",    32'(h_if.x),          32'((k - 1) % 1056));
      check("hd_y",    32'(h_if.y),          32'((k - 1) / 1056));
      check("hd_ls",   32'(h_if.line_start), 32'(k > 1 && (k - 1) % 1056 == 0));
      if (!h_hs_prev && h_if.hsync && h_hs_rise < 0) h_hs_rise = int'(h_if.x);
      if (h_hs_prev && !h_if.hsync && h_hs_fall < 0) h_hs_fall = int'(h_if.x);
      if (h_if.hsync && k < 1057) h_hs_high++;
      h_hs_prev = h_if.hsync;

      // Tiny mode: whole frames, vsync/vblank sampled mid-line.
      p = k / 2;
      check("sm_tick", 32'(s_if.pixel_tick),  32'(k % 2 == 1));
      check("sm_x",    32'(s_if.x),           32'(p % 15));
      check("sm_y",    32'(s_if.y),           32'((p / 15) % 8));
      check("sm_fs",   32'(s_if.frame_start), 32'(k % 240 == 0));
      if (k % 2 == 1 && p % 15 == 7) begin
        ym = (p / 15) % 8;
        check("sm_vsync",  32'(s_if.vsync),  32'(!(ym >= 5 && ym <= 6)));
        check("sm_vblank", 32'(s_if.vblank), 32'(ym >= 4));
      end
    end

    // Line-0 sync / active window edges.
    check("def_hs_fall_x",   32'(d_hs_fall), 32'(656 + PD));
    check("def_hs_rise_x",   32'(d_hs_rise), 32'(752 + PD));
    check("def_av_fall_x",   32'(d_av_fall), 32'(640 + PD));
    check("def_hs_low_clks", 32'(d_hs_low),  32'd384);
    check("hd_hs_rise_x",    32'(h_hs_rise), 32'(840 + PD));
    check("hd_hs_fall_x",    32'(h_hs_fall), 32'(968 + PD));
    check("hd_hs_high_clks", 32'(h_hs_high), 32'd128);

    // Reset pulse in the middle of the default-mode hsync pulse (line 1, x=700).
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (d_if.x == 10'd700) found = 1'b1;
    end
    check("def_seek700", 32'(found),       32'(1'b1));
    check("def_mid_hs",  32'(d_if.hsync),  32'(1'b0));
    reset_def = 1'b1;
    @(negedge clk);
    reset_def = 1'b0;
    check("mid_rst_x",      32'(d_if.x),           32'd0);
    check("mid_rst_y",      32'(d_if.y),           32'd0);
    check("mid_rst_hsync",  32'(d_if.hsync),       32'(1'b1));
    check("mid_rst_vsync",  32'(d_if.vsync),       32'(1'b1));
    check("mid_rst_active", 32'(d_if.activevideo), 32'(AV_RST));
    check("mid_rst_tick",   32'(d_if.pixel_tick),  32'(1'b0));
    check("mid_rst_ls",     32'(d_if.line_start),  32'(1'b0));
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check("post_rst_tick", 32'(d_if.pixel_tick), 32'(j == 3));
    end
    check("post_rst_x", 32'(d_if.x), 32'd1);

    // Reset pulse in the tiny mode with both syncs asserted (x=12, y=6).
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (s_if.x == 4'd12 && s_if.y == 3'd6) found = 1'b1;
    end
    check("sm_seek",     32'(found),        32'(1'b1));
    check("sm_mid_hs",   32'(s_if.hsync),   32'(1'b0));
    check("sm_mid_vs",   32'(s_if.vsync),   32'(1'b0));
    check("sm_mid_vb",   32'(s_if.vblank),  32'(1'b1));
    reset_sm = 1'b1;
    @(negedge clk);
    reset_sm = 1'b0;
    check("sm_rst_x",      32'(s_if.x),           32'd0);
    check("sm_rst_y",      32'(s_if.y),           32'd0);
    check("sm_rst_hsync",  32'(s_if.hsync),       32'(1'b1));
    check("sm_rst_vsync",  32'(s_if.vsync),       32'(1'b1));
    check("sm_rst_active", 32'(s_if.activevideo), 32'(AV_RST));
    check("sm_rst_vblank", 32'(s_if.vblank),      32'(1'b0));
    @(negedge clk);
    check("sm_post_tick", 32'(s_if.pixel_tick), 32'(1'b1));
    @(negedge clk);
    check("sm_post_x",    32'(s_if.x),          32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
